// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler and motion sequencer for a 3-floor elevator car.
// Optional fire-service recall input is compiled in when ELEVATOR_FIRE_RECALL_EN is defined.
module elevator_call_scheduler #(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] call,
    input  logic       hold,
    input  logic       lock,
`ifdef ELEVATOR_FIRE_RECALL_EN
    input  logic       fire_recall,
`endif
    output logic [2:0] cur_floor,
    output logic [2:0] target,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic [2:0] pending,
    output logic       locked
);

    localparam int unsigned STEP_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int unsigned DOOR_W = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_DOOR   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        cur_nxt, target_nxt, pend_nxt;
    logic              dir_nxt;
    logic [STEP_W-1:0] step_cnt, step_nxt;
    logic [DOOR_W-1:0] door_cnt, door_nxt;

    logic [2:0]        arrive;
    logic              step_done;
    logic              go_up;

    function automatic logic [2:0] above_mask(input logic [2:0] f);
        return {f[1] | f[0], f[0], 1'b0};
    endfunction

    function automatic logic [2:0] below_mask(input logic [2:0] f);
        return {1'b0, f[2], f[2] | f[1]};
    endfunction

    // Nearest pending floor strictly ahead of f in the given direction, 000 if none.
    function automatic logic [2:0] nearest(input logic [2:0] pend, input logic [2:0] f,
                                           input logic up);
        logic [2:0] m;
        m = up ? (pend & above_mask(f)) : (pend & below_mask(f));
        if (up) begin
            if (m[0])      return 3'b001;
            else if (m[1]) return 3'b010;
            else if (m[2]) return 3'b100;
            else           return 3'b000;
        end else begin
            if (m[2])      return 3'b100;
            else if (m[1]) return 3'b010;
            else if (m[0]) return 3'b001;
            else           return 3'b000;
        end
    endfunction

    assign arrive    = dir_up ? {cur_floor[1:0], 1'b0} : {1'b0, cur_floor[2:1]};
    assign step_done = (step_cnt == STEP_W'(TRAVEL_CYCLES - 1));
    // SCAN: keep heading while calls remain ahead, otherwise reverse.
    assign go_up     = dir_up ? (|(pending & above_mask(cur_floor)))
                              : ~(|(pending & below_mask(cur_floor)));

    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur_floor;
        target_nxt = target;
        dir_nxt    = dir_up;
        pend_nxt   = pending | call;
        step_nxt   = step_cnt;
        door_nxt   = door_cnt;

        case (state)
            S_IDLE: begin
                if (lock) begin
                    state_nxt = S_LOCKED;
                    pend_nxt  = '0;
                end else if (|(pending & cur_floor)) begin
                    state_nxt = S_DOOR;
                    pend_nxt  = pend_nxt & ~cur_floor;
                    door_nxt  = DOOR_W'(DOOR_CYCLES);
                end else if (|pending) begin
                    state_nxt  = S_MOVE;
                    dir_nxt    = go_up;
                    target_nxt = nearest(pending, cur_floor, go_up);
                    step_nxt   = '0;
                end
            end
            S_MOVE: begin
                if (step_done) begin
                    step_nxt = '0;
                    cur_nxt  = arrive;
                    if (|(pending & arrive)) begin
                        state_nxt  = S_DOOR;
                        pend_nxt   = pend_nxt & ~arrive;
                        door_nxt   = DOOR_W'(DOOR_CYCLES);
                        target_nxt = '0;
                    end else begin
                        target_nxt = nearest(pending, arrive, dir_up);
                        if (target_nxt == 3'b000) begin
                            state_nxt = S_IDLE;
                        end
                    end
                end else begin
                    step_nxt   = step_cnt + STEP_W'(1);
                    target_nxt = nearest(pending, cur_floor, dir_up);
                end
            end
            S_DOOR: begin
                pend_nxt = pending | (call & ~cur_floor);
                if (hold) begin
                    door_nxt = DOOR_W'(DOOR_CYCLES);
                end else if (door_cnt <= DOOR_W'(1)) begin
                    state_nxt = S_IDLE;
                    door_nxt  = '0;
                end else begin
                    door_nxt = door_cnt - DOOR_W'(1);
                end
            end
            S_LOCKED: begin
                pend_nxt = '0;
                if (!lock) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

`ifdef ELEVATOR_FIRE_RECALL_EN
        // Recall drives the car to floor1 and parks it with the door open; a running step completes.
        if (fire_recall) begin
            pend_nxt = '0;
            if (state == S_MOVE) begin
                if (step_done) begin
                    if (arrive[0]) begin
                        state_nxt  = S_DOOR;
                        door_nxt   = DOOR_W'(DOOR_CYCLES);
                        target_nxt = '0;
                    end else begin
                        state_nxt  = S_MOVE;
                        dir_nxt    = 1'b0;
                        target_nxt = 3'b001;
                    end
                end else begin
                    target_nxt = dir_up ? arrive : 3'b001;
                end
            end else if (cur_floor[0]) begin
                state_nxt  = S_DOOR;
                door_nxt   = DOOR_W'(DOOR_CYCLES);
                target_nxt = '0;
            end else begin
                state_nxt  = S_MOVE;
                dir_nxt    = 1'b0;
                target_nxt = 3'b001;
                step_nxt   = '0;
            end
        end
`endif

        if (cur_nxt[2]) begin
            dir_nxt = 1'b0;
        end else if (cur_nxt[0]) begin
            dir_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_floor <= 3'b001;
            target    <= '0;
            dir_up    <= 1'b1;
            pending   <= '0;
            step_cnt  <= '0;
            door_cnt  <= '0;
            moving    <= 1'b0;
            door_open <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_floor <= cur_nxt;
            target    <= target_nxt;
            dir_up    <= dir_nxt;
            pending   <= pend_nxt;
            step_cnt  <= step_nxt;
            door_cnt  <= door_nxt;
            moving    <= (state_nxt == S_MOVE);
            door_open <= (state_nxt == S_DOOR);
            locked    <= (state_nxt == S_LOCKED);
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed vector table, hand sequences, and random run vs. a floor-level model.
module tb_elevator_call_scheduler;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] call;
    logic       hold;
    logic       lock;
    logic [2:0] cur_floor, target, pending;
    logic       moving, dir_up, door_open, locked;

    int n_checks = 0;
    int n_errors = 0;

    elevator_call_scheduler #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
        .clk(clk), .reset(reset), .call(call), .hold(hold), .lock(lock),
        .cur_floor(cur_floor), .target(target), .moving(moving), .dir_up(dir_up),
        .door_open(door_open), .pending(pending), .locked(locked)
    );

    always #5 clk = ~clk;

    // Observation bundle: {cur_floor, target, moving, dir_up, door_open, pending, locked}
    function automatic logic [12:0] pk(input logic [2:0] c, input logic [2:0] t, input logic m,
                                       input logic d, input logic o, input logic [2:0] p,
                                       input logic l);
        return {c, t, m, d, o, p, l};
    endfunction

    function automatic logic [12:0] observed();
        return pk(cur_floor, target, moving, dir_up, door_open, pending, locked);
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got {cur,tgt,mov,up,door,pend,lck}=%b required %b",
                     name, $time, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got %b required %b", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model (floor numbers 0..2) ----------------
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_LOCK = 3;
    int       m_mode, m_floor, m_target, m_travel, m_door;
    bit       m_up;
    bit [2:0] m_pend;

    function automatic int m_nearest(input bit [2:0] p, input int from, input bit up);
        if (up) begin
            for (int i = from + 1; i <= 2; i++) if (p[i]) return i;
        end else begin
            for (int i = from - 1; i >= 0; i--) if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_floor = 0; m_target = -1; m_travel = 0; m_door = 0;
        m_up = 1'b1; m_pend = '0;
    endtask

    task automatic model_step(input bit [2:0] c, input bit h, input bit l);
        bit [2:0] np;
        bit       any_above, any_below;
        np = m_pend | c;
        any_above = (m_nearest(m_pend, m_floor, 1'b1) >= 0);
        any_below = (m_nearest(m_pend, m_floor, 1'b0) >= 0);
        case (m_mode)
            M_IDLE: begin
                if (l) begin
                    m_mode = M_LOCK; np = '0;
                end else if (m_pend[m_floor]) begin
                    m_mode = M_DOOR; m_door = DOOR; np[m_floor] = 1'b0;
                end else if (m_pend != 0) begin
                    if (m_up) m_up = any_above;
                    else      m_up = !any_below;
                    m_target = m_nearest(m_pend, m_floor, m_up);
                    m_mode = M_MOVE; m_travel = 0;
                end
            end
            M_MOVE: begin
                m_travel++;
                if (m_travel == TRAVEL) begin
                    m_travel = 0;
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    if (m_pend[m_floor]) begin
                        m_mode = M_DOOR; m_door = DOOR; m_target = -1; np[m_floor] = 1'b0;
                    end else begin
                        m_target = m_nearest(m_pend, m_floor, m_up);
                        if (m_target < 0) m_mode = M_IDLE;
                    end
                end else begin
                    m_target = m_nearest(m_pend, m_floor, m_up);
                end
            end
            M_DOOR: begin
                np = m_pend | c;
                np[m_floor] = m_pend[m_floor];
                if (h) m_door = DOOR;
                else if (m_door == 1) m_mode = M_IDLE;
                else m_door--;
            end
            default: begin
                np = '0;
                if (!l) m_mode = M_IDLE;
            end
        endcase
        if (m_floor == 2) m_up = 1'b0;
        if (m_floor == 0) m_up = 1'b1;
        m_pend = np;
    endtask

    function automatic logic [12:0] model_obs();
        logic [2:0] cf, tg;
        cf = 3'(1 << m_floor);
        tg = (m_target < 0) ? 3'b000 : 3'(1 << m_target);
        return pk(cf, tg, m_mode == M_MOVE, m_up, m_mode == M_DOOR, m_pend, m_mode == M_LOCK);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  call;
        logic        hold;
        logic        lock;
        int          n;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{3'b100, 1'b0, 1'b0, 1, pk(3'b001, 3'b000, 0, 1, 0, 3'b100, 0)};
        vecs[1]  = '{3'b000, 1'b0, 1'b0, 1, pk(3'b001, 3'b100, 1, 1, 0, 3'b100, 0)};
        vecs[2]  = '{3'b000, 1'b0, 1'b0, 8, pk(3'b010, 3'b100, 1, 1, 0, 3'b100, 0)};
        vecs[3]  = '{3'b000, 1'b0, 1'b0, 8, pk(3'b100, 3'b000, 0, 0, 1, 3'b000, 0)};
        vecs[4]  = '{3'b000, 1'b0, 1'b0, 3, pk(3'b100, 3'b000, 0, 0, 1, 3'b000, 0)};
        vecs[5]  = '{3'b000, 1'b0, 1'b0, 1, pk(3'b100, 3'b000, 0, 0, 0, 3'b000, 0)};
        vecs[6]  = '{3'b010, 1'b0, 1'b1, 1, pk(3'b100, 3'b000, 0, 0, 0, 3'b000, 1)};
        vecs[7]  = '{3'b111, 1'b0, 1'b1, 3, pk(3'b100, 3'b000, 0, 0, 0, 3'b000, 1)};
        vecs[8]  = '{3'b000, 1'b0, 1'b0, 1, pk(3'b100, 3'b000, 0, 0, 0, 3'b000, 0)};
        vecs[9]  = '{3'b000, 1'b0, 1'b0, 1, pk(3'b100, 3'b000, 0, 0, 0, 3'b000, 0)};
        vecs[10] = '{3'b011, 1'b0, 1'b0, 1, pk(3'b100, 3'b000, 0, 0, 0, 3'b011, 0)};
        vecs[11] = '{3'b000, 1'b0, 1'b0, 1, pk(3'b100, 3'b010, 1, 0, 0, 3'b011, 0)};
        vecs[12] = '{3'b000, 1'b0, 1'b0, 8, pk(3'b010, 3'b000, 0, 0, 1, 3'b001, 0)};
        vecs[13] = '{3'b000, 1'b0, 1'b0, 4, pk(3'b010, 3'b000, 0, 0, 0, 3'b001, 0)};
        vecs[14] = '{3'b000, 1'b0, 1'b0, 1, pk(3'b010, 3'b001, 1, 0, 0, 3'b001, 0)};
        vecs[15] = '{3'b000, 1'b0, 1'b0, 8, pk(3'b001, 3'b000, 0, 1, 1, 3'b000, 0)};
        vecs[16] = '{3'b000, 1'b0, 1'b0, 4, pk(3'b001, 3'b000, 0, 1, 0, 3'b000, 0)};
    end

    initial begin
        logic [12:0] rst_val;
        logic        lk;
        rst_val = pk(3'b001, 3'b000, 0, 1, 0, 3'b000, 0);
        call = '0; hold = 1'b0; lock = 1'b0; reset = 1'b1;
        tick(2);
        check("reset_state", observed(), rst_val);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            call = vecs[i].call; hold = vecs[i].hold; lock = vecs[i].lock;
            tick(1);
            call = '0;
            if (vecs[i].n > 1) tick(vecs[i].n - 1);
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        // Door hold at floor1; a call for the open floor is absorbed.
        call = 3'b001; tick(1); call = '0; tick(1);
        check("hold_door_entry", observed(), pk(3'b001, 3'b000, 0, 1, 1, 3'b000, 0));
        hold = 1'b1; call = 3'b001; tick(5); call = '0; tick(5);
        check("hold_10_cycles", observed(), pk(3'b001, 3'b000, 0, 1, 1, 3'b000, 0));
        hold = 1'b0; tick(3);
        check_bit("hold_release_plus3", door_open, 1'b1);
        tick(1);
        check_bit("hold_release_plus4", door_open, 1'b0);

        // Heading up: floor3 served before the later floor1 call.
        call = 3'b100; tick(1); call = '0; tick(1);
        tick(8);
        check("scan_at_floor2", observed(), pk(3'b010, 3'b100, 1, 1, 0, 3'b100, 0));
        tick(3); call = 3'b001; tick(1); call = '0; tick(4);
        check("scan_floor3_first", observed(), pk(3'b100, 3'b000, 0, 0, 1, 3'b001, 0));
        tick(4); tick(1);
        check("scan_reverse", observed(), pk(3'b100, 3'b001, 1, 0, 0, 3'b001, 0));
        tick(8);
        check("scan_pass_floor2", observed(), pk(3'b010, 3'b001, 1, 0, 0, 3'b001, 0));
        tick(8);
        check("scan_arrive_floor1", observed(), pk(3'b001, 3'b000, 0, 1, 1, 3'b000, 0));
        tick(4);

        // Asynchronous reset mid-step between floor2 and floor3.
        call = 3'b100; tick(1); call = '0; tick(1); tick(8 + 3);
        check_bit("pre_reset_floor2", cur_floor[1], 1'b1);
        #2 reset = 1'b1;
        #1 check("async_reset_midstep", observed(), rst_val);
        @(negedge clk); reset = 1'b0;
        tick(1);
        check("after_reset_idle", observed(), rst_val);

        // Randomised run against the floor-level model.
        reset = 1'b1; tick(1); model_reset();
        @(negedge clk); reset = 1'b0;
        lk = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [2:0] c;
            for (int b = 0; b < 3; b++) c[b] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) lk = ~lk;
            call = c; hold = ($urandom_range(0, 5) == 0); lock = lk;
            @(posedge clk);
            model_step(c, hold, lk);
            #1;
            check($sformatf("rand%0d", cyc), observed(), model_obs());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
